// File: rtl/gen_gray_ptr_bank_pkg.sv
// ---------------------------------------------------------------------------
// gen_gray_ptr_bank_pkg
//   Shared definitions for the gray pointer bank:
//     GG_MODE_WRAP / GG_MODE_SAT : end-behaviour selectors for SAT_MODE
//     bin2gray                   : binary to reflected-gray conversion
// ---------------------------------------------------------------------------
package gen_gray_ptr_bank_pkg;

  localparam int GG_MODE_WRAP = 0;
  localparam int GG_MODE_SAT  = 1;

  // Width-agnostic conversion. Callers zero-extend into 32 bits and truncate
  // the result back to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gen_gray_ptr_bank_ch.sv
// ---------------------------------------------------------------------------
// gen_gray_ptr_bank_ch
//   One gray/binary pointer channel: next-value arithmetic, end detection and
//   the bin / gray / end_pulse registers.
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     flush        load strobe, takes load_bin on the next edge
//     load_bin     binary load value
//     enable       count enable
//     down         1 = decrement, 0 = increment
//     step         step amount (0 = hold)
//     count_gray   registered gray pointer
//     count_bin    registered binary pointer
//     end_pulse    one-cycle pulse on wrap (wrap mode) or clamp (saturate mode)
// ---------------------------------------------------------------------------
module gen_gray_ptr_bank_ch
  import gen_gray_ptr_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_W   = 2,
  parameter int SAT_MODE = GG_MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [WIDTH-1:0]  load_bin,
  input  logic              enable,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count_gray,
  output logic [WIDTH-1:0]  count_bin,
  output logic              end_pulse
);

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             end_reg, end_next;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum_ext;
  logic             overflow;

  always_comb begin
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    if (down) begin
      sum_ext = {1'b0, bin_reg} - step_ext;
    end else begin
      sum_ext = {1'b0, bin_reg} + step_ext;
    end
    // Bit WIDTH is the carry when adding and the borrow when subtracting:
    // both operands are below 2^WIDTH, so a negative difference shows up there.
    overflow = sum_ext[WIDTH];

    bin_next = bin_reg;
    end_next = 1'b0;
    if (flush) begin
      bin_next = load_bin;
    end else if (enable && (step != '0)) begin
      if (overflow) begin
        end_next = 1'b1;
        if (SAT_MODE == GG_MODE_SAT) begin
          // Clamp to the bound in the direction of travel; already sitting
          // at the bound also lands here, so the pulse repeats every cycle.
          bin_next = down ? '0 : '1;
        end else begin
          bin_next = sum_ext[WIDTH-1:0];
        end
      end else begin
        bin_next = sum_ext[WIDTH-1:0];
      end
    end
    gray_next = WIDTH'(bin2gray(32'(bin_next)));
  end

  // Gray is derived from the same next value as binary, so both registers
  // always describe the same pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      end_reg  <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      end_reg  <= end_next;
    end
  end

  assign count_bin  = bin_reg;
  assign count_gray = gray_reg;
  assign end_pulse  = end_reg;

endmodule

// File: rtl/gen_gray_ptr_bank.sv
// ---------------------------------------------------------------------------
// gen_gray_ptr_bank
//   Bank of NUM_CH independent gray-code pointer counters.
//   Ports (channel c occupies slice [c*WIDTH +: WIDTH] / [c*STEP_W +: STEP_W]):
//     clk, reset   rising-edge clock, synchronous active-high reset
//     flush        per-channel load strobe
//     load_bin     per-channel binary load value
//     enable       per-channel count enable
//     down         per-channel direction, 1 = decrement
//     step         per-channel step amount
//     count_gray   per-channel registered gray pointer
//     count_bin    per-channel registered binary pointer
//     end_pulse    per-channel wrap/clamp pulse
// ---------------------------------------------------------------------------
module gen_gray_ptr_bank
  import gen_gray_ptr_bank_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 4,
  parameter int STEP_W   = 2,
  parameter int SAT_MODE = GG_MODE_WRAP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        flush,
  input  logic [NUM_CH*WIDTH-1:0]  load_bin,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH-1:0]        down,
  input  logic [NUM_CH*STEP_W-1:0] step,
  output logic [NUM_CH*WIDTH-1:0]  count_gray,
  output logic [NUM_CH*WIDTH-1:0]  count_bin,
  output logic [NUM_CH-1:0]        end_pulse
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    gen_gray_ptr_bank_ch #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .SAT_MODE (SAT_MODE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush[gi]),
      .load_bin   (load_bin[gi*WIDTH +: WIDTH]),
      .enable     (enable[gi]),
      .down       (down[gi]),
      .step       (step[gi*STEP_W +: STEP_W]),
      .count_gray (count_gray[gi*WIDTH +: WIDTH]),
      .count_bin  (count_bin[gi*WIDTH +: WIDTH]),
      .end_pulse  (end_pulse[gi])
    );
  end

endmodule

// File: tb/tb_gen_gray_ptr_bank.sv
module tb_gen_gray_ptr_bank;

  localparam int N = 2;
  localparam int W = 4;
  localparam int S = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] flush, enable, down;
  logic [N*W-1:0] load_bin;
  logic [N*S-1:0] step;
  logic [N*W-1:0] gray_w, bin_w, gray_s, bin_s;
  logic [N-1:0]   end_w, end_s;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers per channel, for wrap and saturate banks.
  int m_bin_w[N], m_end_w[N], m_bin_s[N], m_end_s[N];

  always #5 clk = ~clk;

  gen_gray_ptr_bank #(.NUM_CH(N), .WIDTH(W), .STEP_W(S), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .reset(reset), .flush(flush), .load_bin(load_bin), .enable(enable),
    .down(down), .step(step), .count_gray(gray_w), .count_bin(bin_w), .end_pulse(end_w)
  );

  gen_gray_ptr_bank #(.NUM_CH(N), .WIDTH(W), .STEP_W(S), .SAT_MODE(1)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .load_bin(load_bin), .enable(enable),
    .down(down), .step(step), .count_gray(gray_s), .count_bin(bin_s), .end_pulse(end_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Model of one edge from the spec rules, using ordinary integer arithmetic.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      int st, raw;
      st = int'(step[c*S +: S]);
      if (reset) begin
        m_bin_w[c] = 0; m_end_w[c] = 0; m_bin_s[c] = 0; m_end_s[c] = 0;
      end else if (flush[c]) begin
        m_bin_w[c] = int'(load_bin[c*W +: W]); m_end_w[c] = 0;
        m_bin_s[c] = int'(load_bin[c*W +: W]); m_end_s[c] = 0;
      end else if (enable[c] && st != 0) begin
        raw = down[c] ? m_bin_w[c] - st : m_bin_w[c] + st;
        m_end_w[c] = (raw < 0 || raw > MAXV) ? 1 : 0;
        m_bin_w[c] = (raw + (MAXV + 1)) % (MAXV + 1);
        raw = down[c] ? m_bin_s[c] - st : m_bin_s[c] + st;
        m_end_s[c] = (raw < 0 || raw > MAXV) ? 1 : 0;
        m_bin_s[c] = raw < 0 ? 0 : (raw > MAXV ? MAXV : raw);
      end else begin
        m_end_w[c] = 0; m_end_s[c] = 0;
      end
    end
  endtask

  // One clock: advance model, sample #1 after the edge, compare everything.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < N; c++) begin
      chk($sformatf("%s wrap ch%0d bin", tag, c),  32'(bin_w[c*W +: W]),  32'(m_bin_w[c]));
      chk($sformatf("%s wrap ch%0d gray", tag, c), 32'(gray_w[c*W +: W]), 32'(gray_of(m_bin_w[c])));
      chk($sformatf("%s wrap ch%0d end", tag, c),  32'(end_w[c]),         32'(m_end_w[c]));
      chk($sformatf("%s sat ch%0d bin", tag, c),   32'(bin_s[c*W +: W]),  32'(m_bin_s[c]));
      chk($sformatf("%s sat ch%0d gray", tag, c),  32'(gray_s[c*W +: W]), 32'(gray_of(m_bin_s[c])));
      chk($sformatf("%s sat ch%0d end", tag, c),   32'(end_s[c]),         32'(m_end_s[c]));
    end
    $display("cycle %s: wrap bin=%h end=%b sat bin=%h end=%b", tag, bin_w, end_w, bin_s, end_s);
  endtask

  task automatic set_ch(input int c, input bit fl, input int ld, input bit en, input bit dn, input int st);
    flush[c] = fl;
    load_bin[c*W +: W] = W'(ld);
    enable[c] = en;
    down[c] = dn;
    step[c*S +: S] = S'(st);
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    reset = 1'b1; flush = '0; load_bin = '0; enable = '0; down = '0; step = '0;
    for (int c = 0; c < N; c++) begin
      m_bin_w[c] = 0; m_end_w[c] = 0; m_bin_s[c] = 0; m_end_s[c] = 0;
    end

    // 1 Reset with counting requested, then release.
    set_ch(0, 0, 0, 1, 0, 1); set_ch(1, 0, 0, 1, 0, 1);
    tick("reset");
    chk("reset bin0 zero", 32'(bin_w[3:0]), 32'd0);
    reset = 1'b0;
    tick("release");
    chk("release bin0", 32'(bin_w[3:0]), 32'd1);
    chk("release gray0", 32'(gray_w[3:0]), 32'b0001);

    // 2 Wrap sweep on ch0 from 0.
    set_ch(0, 1, 0, 0, 0, 0); set_ch(1, 1, 0, 0, 0, 0);
    tick("flush0");
    set_ch(0, 0, 0, 1, 0, 1); set_ch(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      prev_gray = gray_w[3:0];
      tick($sformatf("sweep%0d", i));
      chk("sweep gray 1-bit", 32'($countones(prev_gray ^ gray_w[3:0])), 32'd1);
      chk("sweep end", 32'(end_w[0]), (i == 16) ? 32'd1 : 32'd0);
    end

    // 3 Step / down on wrap bank.
    set_ch(0, 1, 14, 0, 0, 0); tick("ld14");
    set_ch(0, 0, 0, 1, 0, 3);  tick("14+3");
    chk("14+3 bin", 32'(bin_w[3:0]), 32'd1);
    chk("14+3 end", 32'(end_w[0]), 32'd1);
    set_ch(0, 0, 0, 1, 1, 2);  tick("1-2");
    chk("1-2 bin", 32'(bin_w[3:0]), 32'd15);
    chk("1-2 end", 32'(end_w[0]), 32'd1);
    set_ch(0, 0, 0, 1, 0, 0);  tick("step0");
    chk("step0 hold", 32'(bin_w[3:0]), 32'd15);
    chk("step0 end", 32'(end_w[0]), 32'd0);

    // 4 Saturate bank.
    set_ch(0, 1, 13, 0, 0, 0); tick("ld13");
    set_ch(0, 0, 0, 1, 0, 3);  tick("sat13+3");
    chk("sat clamp bin", 32'(bin_s[3:0]), 32'd15);
    chk("sat clamp end", 32'(end_s[0]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick("sathold");
      chk("sat hold bin", 32'(bin_s[3:0]), 32'd15);
      chk("sat hold end", 32'(end_s[0]), 32'd1);
    end
    set_ch(0, 1, 3, 0, 0, 0); tick("ld3");
    set_ch(0, 0, 0, 1, 1, 3); tick("sat3-3");
    chk("sat land bin", 32'(bin_s[3:0]), 32'd0);
    chk("sat land end", 32'(end_s[0]), 32'd0);

    // 5 Flush priority over enable, reset priority over flush.
    set_ch(0, 1, 9, 1, 0, 1); tick("flush9");
    chk("flush9 bin", 32'(bin_w[3:0]), 32'd9);
    chk("flush9 gray", 32'(gray_w[3:0]), 32'b1101);
    chk("flush9 end", 32'(end_w[0]), 32'd0);
    reset = 1'b1; tick("flushrst");
    chk("flush+reset bin", 32'(bin_w[3:0]), 32'd0);
    reset = 1'b0;

    // 6 Multi-channel: ch0 counts up while ch1 loads 5 then counts down.
    set_ch(0, 0, 0, 1, 0, 1); set_ch(1, 1, 5, 1, 0, 2); tick("mc_load");
    chk("mc ch1 load", 32'(bin_w[7:4]), 32'd5);
    set_ch(1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 7; i++) tick($sformatf("mc%0d", i));
    chk("mc ch0 indep", 32'(bin_w[3:0]), 32'd8);
    chk("mc ch1 indep", 32'(bin_w[7:4]), 32'd14);

    // Random regression against the model.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < N; c++)
        set_ch(c, $urandom_range(0, 7) == 0, $urandom_range(0, MAXV),
               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      tick($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
